mem_access_unit: RTL and testbench

- Multi-cycle load/store engine placed directly downstream of the CPU's MEM-stage address/data (ALU result, rt bus, MemWr).
- Converts each CPU access into a req/ack transaction on a word-wide memory port, with byte lanes and load extension.
- Holds the core with `stall` until the access retires.
- Replaces the direct single-cycle `dm_4k` hookup so slow memories and peripherals can attach.

---
 rtl/mem_access_unit.sv | 211 +++++++++++++++++++++
 tb/tb_mem_access_unit.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// Multi-cycle load/store engine: turns CPU MEM-stage accesses into req/ack word transactions with byte lanes and load extension.
// Optional build macro MAU_PERF_CNT_EN adds saturating retired-access and stall-cycle counters.
module mem_access_unit #(
  parameter int ADDR_W  = 10,
  parameter int TIMEOUT = 15
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              mem_en_i,
  input  logic              mem_wr_i,
  input  logic [1:0]        size_i,
  input  logic              sign_ext_i,
  input  logic [31:0]       addr_i,
  input  logic [31:0]       wdata_i,
  output logic [31:0]       rdata_o,
  output logic              stall_o,
  output logic              addr_err_o,
  output logic              bus_err_o,
  output logic              m_req_o,
  output logic              m_we_o,
  output logic [ADDR_W-3:0] m_addr_o,
  output logic [3:0]        m_be_o,
  output logic [31:0]       m_wdata_o,
  input  logic [31:0]       m_rdata_i,
  input  logic              m_ack_i
`ifdef MAU_PERF_CNT_EN
  ,
  output logic [15:0]       perf_acc_o,
  output logic [15:0]       perf_stall_o
`endif
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_DONE   = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [1:0]        off_q, off_d;
  logic [1:0]        size_q, size_d;
  logic              sext_q, sext_d;
  logic [7:0]        timer_q, timer_d;
  logic              m_req_q, m_req_d;
  logic              m_we_q, m_we_d;
  logic [ADDR_W-3:0] m_addr_q, m_addr_d;
  logic [3:0]        m_be_q, m_be_d;
  logic [31:0]       m_wdata_q, m_wdata_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              addr_err_q, addr_err_d;
  logic              bus_err_q, bus_err_d;

  logic              misalign;
  logic [3:0]        be_dec;
  logic [31:0]       wd_dec;
  logic [31:0]       rd_sh;
  logic [31:0]       ld_val;
  logic              unused_addr;

  assign unused_addr = ^addr_i[31:ADDR_W];

  assign misalign = (size_i == 2'b11) ||
                    ((size_i == 2'b01) && addr_i[0]) ||
                    ((size_i == 2'b10) && (addr_i[1:0] != 2'b00));

  always_comb begin
    be_dec = 4'b1111;
    wd_dec = wdata_i;
    case (size_i)
      2'b00: begin
        be_dec = 4'b0001 << addr_i[1:0];
        wd_dec = {4{wdata_i[7:0]}};
      end
      2'b01: begin
        be_dec = addr_i[1] ? 4'b1100 : 4'b0011;
        wd_dec = {2{wdata_i[15:0]}};
      end
      default: ;
    endcase
  end

  // Move the addressed lane(s) down to bit 0 before extending.
  assign rd_sh = m_rdata_i >> {off_q, 3'b000};

  always_comb begin
    ld_val = m_rdata_i;
    case (size_q)
      2'b00:   ld_val = {{24{sext_q & rd_sh[7]}}, rd_sh[7:0]};
      2'b01:   ld_val = {{16{sext_q & rd_sh[15]}}, rd_sh[15:0]};
      default: ;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    off_d      = off_q;
    size_d     = size_q;
    sext_d     = sext_q;
    timer_d    = timer_q;
    m_req_d    = m_req_q;
    m_we_d     = m_we_q;
    m_addr_d   = m_addr_q;
    m_be_d     = m_be_q;
    m_wdata_d  = m_wdata_q;
    rdata_d    = rdata_q;
    addr_err_d = addr_err_q;
    bus_err_d  = bus_err_q;
    case (state_q)
      S_IDLE: begin
        if (mem_en_i) begin
          off_d     = addr_i[1:0];
          size_d    = size_i;
          sext_d    = sign_ext_i;
          timer_d   = 8'd0;
          m_addr_d  = addr_i[ADDR_W-1:2];
          m_be_d    = be_dec;
          m_wdata_d = wd_dec;
          if (misalign) begin
            addr_err_d = 1'b1;
            state_d    = S_DONE;
          end else begin
            m_req_d = 1'b1;
            m_we_d  = mem_wr_i;
            state_d = S_ACCESS;
          end
        end
      end
      S_ACCESS: begin
        if (m_ack_i) begin
          if (!m_we_q) rdata_d = ld_val;
          m_req_d = 1'b0;
          m_we_d  = 1'b0;
          state_d = S_DONE;
        end else if (timer_q == 8'(TIMEOUT - 1)) begin
          rdata_d   = 32'd0;
          bus_err_d = 1'b1;
          m_req_d   = 1'b0;
          m_we_d    = 1'b0;
          state_d   = S_DONE;
        end else begin
          timer_d = timer_q + 8'd1;
        end
      end
      S_DONE: begin
        addr_err_d = 1'b0;
        bus_err_d  = 1'b0;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= S_IDLE;
      off_q      <= 2'd0;
      size_q     <= 2'd0;
      sext_q     <= 1'b0;
      timer_q    <= 8'd0;
      m_req_q    <= 1'b0;
      m_we_q     <= 1'b0;
      m_addr_q   <= '0;
      m_be_q     <= 4'd0;
      m_wdata_q  <= 32'd0;
      rdata_q    <= 32'd0;
      addr_err_q <= 1'b0;
      bus_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      off_q      <= off_d;
      size_q     <= size_d;
      sext_q     <= sext_d;
      timer_q    <= timer_d;
      m_req_q    <= m_req_d;
      m_we_q     <= m_we_d;
      m_addr_q   <= m_addr_d;
      m_be_q     <= m_be_d;
      m_wdata_q  <= m_wdata_d;
      rdata_q    <= rdata_d;
      addr_err_q <= addr_err_d;
      bus_err_q  <= bus_err_d;
    end
  end

  assign stall_o    = mem_en_i && (state_q != S_DONE);
  assign rdata_o    = rdata_q;
  assign addr_err_o = addr_err_q;
  assign bus_err_o  = bus_err_q;
  assign m_req_o    = m_req_q;
  assign m_we_o     = m_we_q;
  assign m_addr_o   = m_addr_q;
  assign m_be_o     = m_be_q;
  assign m_wdata_o  = m_wdata_q;

`ifdef MAU_PERF_CNT_EN
  logic [15:0] perf_acc_q, perf_stall_q;

  // DONE is visited once per access, errored or not, so it marks retirement.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      perf_acc_q   <= 16'd0;
      perf_stall_q <= 16'd0;
    end else begin
      if ((state_q == S_DONE) && (perf_acc_q != 16'hFFFF)) perf_acc_q <= perf_acc_q + 16'd1;
      if (stall_o && (perf_stall_q != 16'hFFFF)) perf_stall_q <= perf_stall_q + 16'd1;
    end
  end

  assign perf_acc_o   = perf_acc_q;
  assign perf_stall_o = perf_stall_q;
`endif

endmodule

// File: tb/tb_mem_access_unit.sv
// Randomized bench for mem_access_unit: a word-array memory model answers requests and predicts lanes, load data, errors and timing.
module tb_mem_access_unit;
  localparam int ADDR_W  = 10;
  localparam int TIMEOUT = 15;
  localparam int NEVER   = 1000;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        mem_en_i = 1'b0, mem_wr_i = 1'b0, sign_ext_i = 1'b0, m_ack_i = 1'b0;
  logic [1:0]  size_i = 2'd0;
  logic [31:0] addr_i = 32'd0, wdata_i = 32'd0, m_rdata_i = 32'd0;
  logic [31:0] rdata_o, m_wdata_o;
  logic        stall_o, addr_err_o, bus_err_o, m_req_o, m_we_o;
  logic [ADDR_W-3:0] m_addr_o;
  logic [3:0]  m_be_o;

  int          checks = 0;
  int          failures = 0;
  logic [31:0] mem [0:255];
  logic [31:0] last_rdata = 32'd0;

  always #5 clk_i = ~clk_i;

  mem_access_unit #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .mem_en_i(mem_en_i), .mem_wr_i(mem_wr_i),
    .size_i(size_i), .sign_ext_i(sign_ext_i), .addr_i(addr_i), .wdata_i(wdata_i),
    .rdata_o(rdata_o), .stall_o(stall_o), .addr_err_o(addr_err_o), .bus_err_o(bus_err_o),
    .m_req_o(m_req_o), .m_we_o(m_we_o), .m_addr_o(m_addr_o), .m_be_o(m_be_o),
    .m_wdata_o(m_wdata_o), .m_rdata_i(m_rdata_i), .m_ack_i(m_ack_i)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] load_val(input logic [31:0] w, input logic [1:0] sz,
                                           input logic sx, input int off);
    logic [31:0] v;
    v = w;
    if (sz == 2'd0) begin
      v = (w >> (8 * off)) & 32'hFF;
      if (sx && v >= 32'h80) v = v + 32'hFFFFFF00;
    end else if (sz == 2'd1) begin
      v = (w >> (8 * off)) & 32'hFFFF;
      if (sx && v >= 32'h8000) v = v + 32'hFFFF0000;
    end
    return v;
  endfunction

  // One CPU access; dly = number of ACCESS cycles before the ack cycle (NEVER = no ack).
  task automatic run_acc(input logic wr, input logic [1:0] sz, input logic sx,
                         input logic [31:0] a, input logic [31:0] wd, input int dly, input bit b2b);
    int          off, idx, stalls, reqs, exp_stalls, exp_reqs;
    bit          exp_err, done;
    logic [3:0]  exp_be;
    logic [31:0] exp_wd, exp_rd, word;
    off     = int'(a[1:0]);
    idx     = int'(a[9:2]);
    exp_err = (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && off != 0);
    exp_be  = (sz == 2'd0) ? 4'(1 << off) : (sz == 2'd1) ? 4'(3 << off) : 4'hF;
    exp_wd  = (sz == 2'd0) ? wd[7:0] * 32'h01010101 :
              (sz == 2'd1) ? wd[15:0] * 32'h00010001 : wd;
    exp_rd  = last_rdata;
    stalls  = 0;
    reqs    = 0;
    done    = 0;
    @(posedge clk_i); #1;
    mem_en_i = 1'b1; mem_wr_i = wr; size_i = sz; sign_ext_i = sx; addr_i = a; wdata_i = wd;
    m_ack_i = 1'b0;
    for (int cyc = 0; cyc < 300 && !done; cyc++) begin
      @(negedge clk_i);
      if (!stall_o) begin
        done = 1;
      end else begin
        stalls++;
        if (m_req_o) begin
          if (reqs == 0) begin
            chk("m_be", 32'(m_be_o), 32'(exp_be));
            chk("m_addr", 32'(m_addr_o), 32'(a[9:2]));
            chk("m_wdata", m_wdata_o, exp_wd);
            chk("m_we", 32'(m_we_o), 32'(wr));
          end
          if (reqs == dly) begin
            word = mem[idx];
            m_rdata_i = word;
            m_ack_i = 1'b1;
            if (wr) begin
              for (int k = 0; k < 4; k++)
                if (exp_be[k]) word[8*k +: 8] = exp_wd[8*k +: 8];
              mem[idx] = word;
            end else begin
              exp_rd = load_val(mem[idx], sz, sx, off);
            end
          end else begin
            m_ack_i = 1'b0;
            m_rdata_i = $urandom;
          end
          reqs++;
          // CPU-side inputs must be ignored once the access is latched.
          mem_wr_i = 1'($urandom); size_i = 2'($urandom); sign_ext_i = 1'($urandom);
          addr_i = $urandom; wdata_i = $urandom;
        end else begin
          m_ack_i = 1'($urandom);
          m_rdata_i = $urandom;
        end
      end
    end
    chk("done_reached", 32'(stall_o), 32'd0);
    m_ack_i = 1'($urandom);
    if (exp_err) begin
      exp_reqs = 0; exp_stalls = 1;
    end else if (dly >= TIMEOUT) begin
      exp_reqs = TIMEOUT; exp_stalls = TIMEOUT + 1; exp_rd = 32'd0;
    end else begin
      exp_reqs = dly + 1; exp_stalls = dly + 2;
    end
    chk("req_cycles", 32'(reqs), 32'(exp_reqs));
    chk("stall_cycles", 32'(stalls), 32'(exp_stalls));
    chk("addr_err", 32'(addr_err_o), 32'(exp_err));
    chk("bus_err", 32'(bus_err_o), 32'(!exp_err && dly >= TIMEOUT));
    chk("rdata", rdata_o, exp_rd);
    last_rdata = exp_rd;
    if (!b2b) begin
      @(posedge clk_i); #1;
      mem_en_i = 1'b0; m_ack_i = 1'b0;
      @(negedge clk_i);
      chk("err_cleared", 32'({addr_err_o, bus_err_o, stall_o}), 32'd0);
    end
  endtask

  initial begin
    int n;
    for (int i = 0; i < 256; i++) mem[i] = $urandom;
    #12;
    chk("rst_outs", 32'({m_req_o, m_we_o, addr_err_o, bus_err_o, stall_o}), 32'd0);
    chk("rst_bus", 32'({m_be_o, m_addr_o}), 32'd0);
    chk("rst_wdata", m_wdata_o, 32'd0);
    chk("rst_rdata", rdata_o, 32'd0);
    @(posedge clk_i); #1;
    rst_ni = 1'b1;

    run_acc(1'b1, 2'd2, 1'b0, 32'h010, 32'hDEADBEEF, 0, 0);
    run_acc(1'b0, 2'd2, 1'b0, 32'h010, 32'h0, 0, 0);
    chk("tp_lw", rdata_o, 32'hDEADBEEF);
    run_acc(1'b1, 2'd2, 1'b0, 32'h010, 32'h80FF1234, 1, 0);
    run_acc(1'b0, 2'd0, 1'b1, 32'h013, 32'h0, 2, 0);
    chk("tp_lb", rdata_o, 32'hFFFFFF80);
    run_acc(1'b0, 2'd0, 1'b0, 32'h013, 32'h0, 0, 0);
    chk("tp_lbu", rdata_o, 32'h00000080);
    run_acc(1'b1, 2'd1, 1'b0, 32'h012, 32'h0000ABCD, 0, 0);
    run_acc(1'b0, 2'd1, 1'b1, 32'h012, 32'h0, 0, 0);
    chk("tp_lh", rdata_o, 32'hFFFFABCD);
    run_acc(1'b0, 2'd2, 1'b0, 32'h011, 32'h0, 0, 0);
    run_acc(1'b0, 2'd3, 1'b0, 32'h010, 32'h0, 0, 0);
    run_acc(1'b0, 2'd2, 1'b0, 32'h020, 32'h0, NEVER, 0);
    chk("tp_timeout_rdata", rdata_o, 32'd0);

    for (int t = 0; t < 150; t++) begin
      logic [31:0] a;
      logic [1:0]  sz;
      int          d;
      sz = 2'($urandom);
      a  = $urandom;
      if ($urandom_range(0, 3) != 0) begin
        if (sz == 2'd2) a[1:0] = 2'b00;
        if (sz == 2'd1) a[0] = 1'b0;
      end
      d = ($urandom_range(0, 15) == 0) ? NEVER : $urandom_range(0, 4);
      run_acc(1'($urandom), sz, 1'($urandom), a, $urandom, d, bit'($urandom_range(0, 2) == 0));
    end

    // Asynchronous reset in the third ACCESS cycle.
    @(posedge clk_i); #1;
    mem_en_i = 1'b1; mem_wr_i = 1'b0; size_i = 2'd2; sign_ext_i = 1'b0; addr_i = 32'h040;
    m_ack_i = 1'b0;
    n = 0;
    for (int cyc = 0; cyc < 20 && n < 3; cyc++) begin
      @(negedge clk_i);
      if (m_req_o) n++;
    end
    chk("rst_mid_reached", 32'(n), 32'd3);
    #2 rst_ni = 1'b0;
    #1;
    chk("rst_mid_req", 32'(m_req_o), 32'd0);
    chk("rst_mid_rdata", rdata_o, 32'd0);
    last_rdata = 32'd0;
    mem_en_i = 1'b0;
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
    @(negedge clk_i);
    chk("rst_mid_idle", 32'({m_req_o, stall_o, bus_err_o, addr_err_o}), 32'd0);
    run_acc(1'b0, 2'd2, 1'b0, 32'h010, 32'h0, 0, 0);
    chk("post_rst_lw", rdata_o, mem[4]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
